// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate-family self-test checkers.
// Holds the sweep FSM state encoding, the vector/output counts, the
// bit positions of y1..y6 and the golden gate function.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC  = 4;
    localparam int NUM_OUTS = 6;

    // Bit positions inside the 6-bit output word (bit0 = y1 ... bit5 = y6)
    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_NOT  = 2;
    localparam int Y_NAND = 3;
    localparam int Y_XOR  = 4;
    localparam int Y_XNOR = 5;

    // Reference behaviour of the NOR-built gate block for one input pair
    function automatic logic [NUM_OUTS-1:0] gate_expected(input logic a, input logic b);
        logic [NUM_OUTS-1:0] y;
        y         = '0;
        y[Y_AND]  = a & b;
        y[Y_OR]   = a | b;
        y[Y_NOT]  = ~a;
        y[Y_NAND] = ~(a & b);
        y[Y_XOR]  = a ^ b;
        y[Y_XNOR] = ~(a ^ b);
        return y;
    endfunction

endpackage

// File: rtl/gate_expect.sv
// Combinational golden model of the two-input gate block.
// Reusable by any checker in the gate family.
module gate_expect
    import gate_chk_pkg::*;
(
    input  logic                a,
    input  logic                b,
    output logic [NUM_OUTS-1:0] y
);

    // Pure function of the current input pair
    always_comb begin
        y = gate_expected(a, b);
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Self-test sweep around the two-input gate block.
// Steps a/b through 00, 01, 10, 11, waits SETTLE_CYCLES per vector,
// samples y_in once per vector and accumulates sticky per-output failure
// flags plus a saturating mismatch count.
// Optional feature: define GATE_CHK_FIRST_FAIL_EN to add first-failure
// capture outputs (first_fail_valid / first_fail_ab / first_fail_y).
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                a_out,
    output logic                b_out,
    input  logic [NUM_OUTS-1:0] y_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [NUM_OUTS-1:0] fail_vec
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic                first_fail_valid,
    output logic [1:0]          first_fail_ab,
    output logic [NUM_OUTS-1:0] first_fail_y
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VEC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          idx;
    logic [1:0]          idx_nxt;
    logic                a_nxt;
    logic                b_nxt;
    logic [3:0]          settle_cnt;
    logic [3:0]          settle_cnt_nxt;
    logic [ERR_W-1:0]    err_nxt;
    logic [NUM_OUTS-1:0] fail_nxt;
    logic [NUM_OUTS-1:0] expected;
    logic [NUM_OUTS-1:0] mism;

    // Number of set bits in a mismatch word (at most 6)
    function automatic logic [2:0] pop_outs(input logic [NUM_OUTS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Add a small increment, clamping at the counter's all-ones value
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                 input logic [2:0]       inc);
        logic [ERR_W+2:0] sum;
        sum = {3'b000, acc} + {{ERR_W{1'b0}}, inc};
        if (|sum[ERR_W+2:ERR_W]) begin
            return '1;
        end
        return sum[ERR_W-1:0];
    endfunction

    gate_expect u_expect (
        .a (a_out),
        .b (b_out),
        .y (expected)
    );

    assign mism = y_in ^ expected;

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-datapath decode for the sweep
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        a_nxt          = a_out;
        b_nxt          = b_out;
        settle_cnt_nxt = settle_cnt;
        err_nxt        = err_count;
        fail_nxt       = fail_vec;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = SETTLE;
                    idx_nxt        = 2'd0;
                    a_nxt          = 1'b0;
                    b_nxt          = 1'b0;
                    settle_cnt_nxt = '0;
                    err_nxt        = '0;
                    fail_nxt       = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_nxt = '0;
                    state_nxt      = SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            SAMPLE: begin
                fail_nxt = fail_vec | mism;
                err_nxt  = sat_add(err_count, pop_outs(mism));
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt          = idx + 2'd1;
                    {a_nxt, b_nxt}   = idx + 2'd1;
                    state_nxt        = SETTLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep datapath registers: vector index, drive pins, settle timer, results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            idx        <= idx_nxt;
            a_out      <= a_nxt;
            b_out      <= b_nxt;
            settle_cnt <= settle_cnt_nxt;
            err_count  <= err_nxt;
            fail_vec   <= fail_nxt;
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic start_taken;
    assign start_taken = start && ((state == IDLE) || (state == DONE));

    // Capture the first failing vector of a sweep; cleared by a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_valid <= 1'b0;
            first_fail_ab    <= 2'b00;
            first_fail_y     <= '0;
        end else if (start_taken) begin
            first_fail_valid <= 1'b0;
            first_fail_ab    <= 2'b00;
            first_fail_y     <= '0;
        end else if ((state == SAMPLE) && (mism != '0) && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_ab    <= {a_out, b_out};
            first_fail_y     <= y_in;
        end
    end
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: table of sweeps with per-vector fault masks,
// randomised rows scored by a sweep-level reference model, plus reset-abort
// and saturation sequences.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       a_out, b_out;
    logic [5:0] y_in;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [5:0] fail_vec;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic       ff_valid;
    logic [1:0] ff_ab;
    logic [5:0] ff_y;
`endif

    logic       start2;
    logic       a2, b2;
    logic [5:0] y2;
    logic       busy2, done2, pass2;
    logic [2:0] err2;
    logic [5:0] fail2;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic       ff_valid2;
    logic [1:0] ff_ab2;
    logic [5:0] ff_y2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
        .y_in(y_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ff_valid), .first_fail_ab(ff_ab), .first_fail_y(ff_y)
`endif
    );

    gate_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
        .y_in(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ff_valid2), .first_fail_ab(ff_ab2), .first_fail_y(ff_y2)
`endif
    );

    // Correct gate-block responses, indexed by vector {a,b}; bit0=y1
    logic [5:0] good_y [4];
    initial begin
        good_y[0] = 6'b101100;  // a=0 b=0
        good_y[1] = 6'b011110;  // a=0 b=1
        good_y[2] = 6'b011010;  // a=1 b=0
        good_y[3] = 6'b100011;  // a=1 b=1
    end

    typedef struct {
        logic [23:0] masks;        // faulty bits per vector, vector v at [6v +: 6]
        logic        noise;        // garbage on y_in while settling
        logic [11:0] busy_starts;  // start pulses during the sweep, by cycle
        logic [7:0]  exp_err;
        logic [5:0]  exp_fail;
        logic        exp_pass;
    } row_t;

    localparam int NROWS = 12;
    row_t rows [NROWS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sweep-level reference: every faulty bit counts once, flags are the union
    task automatic model(input logic [23:0] masks, output logic [7:0] err,
                         output logic [5:0] fail, output logic p);
        int total;
        total = 0;
        fail  = '0;
        for (int v = 0; v < 4; v++) begin
            total += $countones(masks[v*6 +: 6]);
            fail  |= masks[v*6 +: 6];
        end
        err = (total > 255) ? 8'd255 : 8'(total);
        p   = (total == 0);
    endtask

    // One full sweep from a start pulse, checking the drive sequence each cycle
    task automatic run_sweep(input row_t r);
        int v;
        @(negedge clk);
        start = 1'b1;
        y_in  = 6'($urandom);
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            v = k / 3;
            chk("ab_seq", {30'd0, a_out, b_out}, 32'(v));
            chk("busy_done", {30'd0, busy, done}, 32'b10);
            if (k == 0) begin
                chk("clear_err", 32'(err_count), 32'd0);
                chk("clear_fail", 32'(fail_vec), 32'd0);
            end
            if ((k % 3 == 2) || !r.noise)
                y_in = good_y[v] ^ r.masks[v*6 +: 6];
            else
                y_in = 6'($urandom);
            start = r.busy_starts[k];
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_edge", {30'd0, busy, done}, 32'b01);
        chk("ab_hold", {30'd0, a_out, b_out}, 32'd3);
        chk("err_count", 32'(err_count), 32'(r.exp_err));
        chk("fail_vec", 32'(fail_vec), 32'(r.exp_fail));
        chk("pass", 32'(pass), 32'(r.exp_pass));
`ifdef GATE_CHK_FIRST_FAIL_EN
        begin
            logic       fv;
            logic [1:0] fab;
            logic [5:0] fy;
            fv = 1'b0; fab = 2'b00; fy = '0;
            for (int u = 3; u >= 0; u--) begin
                if (r.masks[u*6 +: 6] != 0) begin
                    fv = 1'b1; fab = 2'(u); fy = good_y[u] ^ r.masks[u*6 +: 6];
                end
            end
            chk("ff_valid", 32'(ff_valid), 32'(fv));
            chk("ff_ab", 32'(ff_ab), 32'(fab));
            chk("ff_y", 32'(ff_y), 32'(fy));
        end
`endif
        y_in = 6'($urandom);
        @(negedge clk);
        chk("done_hold", {29'd0, busy, done, pass}, {29'd0, 1'b0, 1'b1, r.exp_pass});
        chk("err_hold", 32'(err_count), 32'(r.exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] e;
        logic [5:0] f;
        logic       p;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; y_in = '0; y2 = '0;

        rows[0] = '{masks: 24'd0, noise: 1'b1, busy_starts: 12'h000,
                    exp_err: 8'd0, exp_fail: 6'b000000, exp_pass: 1'b1};
        rows[1] = '{masks: {6'b000000, 6'b000010, 6'b000010, 6'b000000}, noise: 1'b0,
                    busy_starts: 12'h000, exp_err: 8'd2, exp_fail: 6'b000010, exp_pass: 1'b0};
        rows[2] = '{masks: {6'b100011, 6'b011010, 6'b011110, 6'b101100}, noise: 1'b1,
                    busy_starts: 12'h000, exp_err: 8'd13, exp_fail: 6'b111111, exp_pass: 1'b0};
        rows[3] = '{masks: 24'd0, noise: 1'b0, busy_starts: 12'h088,
                    exp_err: 8'd0, exp_fail: 6'b000000, exp_pass: 1'b1};
        for (int i = 4; i < NROWS; i++) begin
            rows[i].masks       = 24'($urandom & $urandom);
            rows[i].noise       = 1'($urandom);
            rows[i].busy_starts = 12'($urandom);
            model(rows[i].masks, e, f, p);
            rows[i].exp_err  = e;
            rows[i].exp_fail = f;
            rows[i].exp_pass = p;
        end

        // Reset state
        #12;
        chk("rst_ctrl", {27'd0, a_out, b_out, busy, done, pass}, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_fail", 32'(fail_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < NROWS; i++) run_sweep(rows[i]);

        // Reset in the second settle cycle of vector 10 aborts everything
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            y_in = 6'b000000;
            @(negedge clk);
        end
        chk("pre_abort_ab", {30'd0, a_out, b_out}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {27'd0, a_out, b_out, busy, done, pass}, 32'd0);
        chk("abort_err", 32'(err_count), 32'd0);
        chk("abort_fail", 32'(fail_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {30'd0, busy, done}, 32'd0);
        run_sweep(rows[0]);

        // Narrow counter saturates with y_in stuck at zero
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("sat_latency", 32'(n), 32'd8);
        chk("sat_err", 32'(err2), 32'd7);
        chk("sat_fail", 32'(fail2), 32'h3f);
        chk("sat_pass", 32'(pass2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
